// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM shared by the instruction-fetch and
// load/store ports. One transaction is in flight at a time, and its response
// pulses after a fixed latency. The data port has priority over fetch.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        instr_gnt_op,
  output logic        instr_rvalid_op,
  output logic [31:0] instr_rdata_op,
  output logic        instr_err_op,
  input  logic        data_req_ip,
  input  logic        data_we_ip,
  input  logic [2:0]  data_funct3_ip,
  input  logic [31:0] data_addr_ip,
  input  logic [31:0] data_wdata_ip,
  output logic        data_gnt_op,
  output logic        data_rvalid_op,
  output logic [31:0] data_rdata_op,
  output logic        data_err_op
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_data;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        resp_cycle;
  logic        can_accept;
  logic        accept;
  logic        oob;
  logic [1:0]  lane;
  logic [31:0] rd_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] result;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wr_word;

  // Handshake: grants are offered while idle or in the response cycle.
  // The data port wins ties.
  always_comb begin
    resp_cycle   = (state == WAIT) && (cnt == 4'(LATENCY - 1));
    can_accept   = ((state == IDLE) || resp_cycle) && !reset;
    data_gnt_op  = can_accept && data_req_ip;
    instr_gnt_op = can_accept && instr_req_ip && !data_req_ip;
    accept       = data_gnt_op || instr_gnt_op;
  end

  // Decode the latched transaction: error check, byte enables, and load extension.
  always_comb begin
    oob      = ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS));
    lane     = lat_addr[1:0];
    rd_word  = oob ? '0 : mem[lat_addr[AW+1:2]];
    sel_byte = rd_word[{lane, 3'b000} +: 8];
    sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    result   = '0;
    err      = 1'b0;
    be       = '0;
    wr_word  = lat_wdata;
    if (!lat_data) begin
      err    = oob || (lane != 2'b00);
      result = rd_word;
    end else begin
      case (lat_f3)
        3'b000: begin
          err     = oob;
          be      = 4'b0001 << lane;
          wr_word = {4{lat_wdata[7:0]}};
          result  = {{24{sel_byte[7]}}, sel_byte};
        end
        3'b001: begin
          err     = oob || lane[0];
          be      = lane[1] ? 4'b1100 : 4'b0011;
          wr_word = {2{lat_wdata[15:0]}};
          result  = {{16{sel_half[15]}}, sel_half};
        end
        3'b010: begin
          err     = oob || (lane != 2'b00);
          be      = 4'b1111;
          wr_word = lat_wdata;
          result  = rd_word;
        end
        3'b100: begin
          err    = oob || lat_we;
          result = {24'h000000, sel_byte};
        end
        3'b101: begin
          err    = oob || lat_we || lane[0];
          result = {16'h0000, sel_half};
        end
        default: err = 1'b1;
      endcase
      if (lat_we) result = '0;
    end
    if (err) begin
      result = '0;
      be     = '0;
    end
  end

  // Responses are driven only during the response cycle of the owning port.
  always_comb begin
    data_rvalid_op  = resp_cycle && lat_data;
    instr_rvalid_op = resp_cycle && !lat_data;
    data_rdata_op   = data_rvalid_op ? result : '0;
    data_err_op     = data_rvalid_op && err;
    instr_rdata_op  = instr_rvalid_op ? result : '0;
    instr_err_op    = instr_rvalid_op && err;
  end

  // Transaction FSM: latch on acceptance, count latency, then return to idle or chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_data  <= 1'b0;
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      if (accept) begin
        lat_data  <= data_gnt_op;
        lat_we    <= data_gnt_op && data_we_ip;
        lat_f3    <= data_gnt_op ? data_funct3_ip : 3'b010;
        lat_addr  <= data_gnt_op ? data_addr_ip : instr_addr_ip;
        lat_wdata <= data_gnt_op ? data_wdata_ip : '0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (resp_cycle) begin
            cnt <= '0;
            if (!accept) state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit at the response edge. Reset forces IDLE asynchronously, so an
  // interrupted store never reaches this point.
  always_ff @(posedge clock) begin
    if (resp_cycle && lat_data && lat_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[lat_addr[AW+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule
